hes_msg_feeder: RTL and testbench

HES_MSG_FEEDER -- requirements
Module: hes_msg_feeder

---
 rtl/hes_pkg.sv | 5 +
 rtl/hes_byte_fifo.sv | 42 ++++
 rtl/hes_msg_feeder.sv | 91 +++++++++
 tb/tb_hes_msg_feeder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hes_pkg.sv
// hes_pkg: shared FSM state type and byte width for the hash message feeder
package hes_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_DONE} state_t;
endpackage

// File: rtl/hes_byte_fifo.sv
// hes_byte_fifo: power-of-two byte FIFO with simultaneous push/pop and occupancy count
module hes_byte_fifo
  import hes_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [BYTE_W-1:0]             wdata_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [BYTE_W-1:0]             head_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push_i);
      rd_q    <= rd_q + AW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign full_o  = count_q == CW'(FIFO_DEPTH);
  assign empty_o = count_q == '0;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/hes_msg_feeder.sv
// hes_msg_feeder: buffers one upstream message and streams its bytes to a hash core
module hes_msg_feeder
  import hes_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg_valid,
  input  logic [BYTE_W-1:0] msg_data,
  input  logic              msg_last,
  input  logic              msg_empty,
  output logic              msg_ready,
  output logic              start,
  output logic              F_dr,
  output logic [BYTE_W-1:0] M,
  output logic              End_Of_File,
  input  logic              F_rtr,
  input  logic              H_ready,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic ready_d, push, pop, full, empty;
  logic [BYTE_W-1:0] head;
  logic [CW-1:0] count;
  hes_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (msg_data),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .count_o (count)
  );
  // next state, upstream acceptance and FIFO control
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ready_d = 1'b0;
    push    = 1'b0;
    F_dr    = (state_q == S_STREAM) && !empty;
    pop     = F_dr && F_rtr;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        last_d  = 1'b0;
        if (msg_valid && !msg_empty) begin
          push    = 1'b1;
          last_d  = msg_last;
          state_d = S_LOAD;
        end else if (msg_valid && msg_last) begin
          last_d  = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_LOAD, S_STREAM: begin
        ready_d = !last_q && (!full || pop);
        if (msg_valid && ready_d) begin
          push   = !msg_empty;
          last_d = last_q || msg_last;
        end
        if (state_q == S_LOAD) state_d = S_STREAM;
        else if (last_q && count == CW'(pop)) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = H_ready ? S_DONE : S_FLUSH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign msg_ready   = rst_n && ready_d;
  assign M           = F_dr ? head : '0;
  assign start       = (state_q == S_STREAM) || (state_q == S_FLUSH) || (state_q == S_DONE);
  assign End_Of_File = state_q == S_FLUSH;
  assign busy        = state_q != S_IDLE;
  assign done        = state_q == S_DONE;
  // state and end-of-message flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_hes_msg_feeder.sv
// tb_hes_msg_feeder: directed and randomized checks of the message feeder against a queue model
module tb_hes_msg_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic msg_valid = 1'b0, msg_last = 1'b0, msg_empty = 1'b0, F_rtr = 1'b0, H_ready = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic msg_ready, start, F_dr, End_Of_File, busy, done;
  logic [7:0] M;
  int vectors = 0;
  int errs = 0;
  byte unsigned msg_q[$], sent_q[$], got_q[$];
  int xfer_cyc[$];
  int eof_cyc;

  always #5 clk = ~clk;

  hes_msg_feeder #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_last(msg_last), .msg_empty(msg_empty), .msg_ready(msg_ready),
    .start(start), .F_dr(F_dr), .M(M), .End_Of_File(End_Of_File),
    .F_rtr(F_rtr), .H_ready(H_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: F_rtr=1, 1: toggling, 2: random valid/ready, 3: F_rtr=0 until cycle hold
  task automatic run_msg(input int mode, input int hold, input int abort_at);
    int idx = 0;
    int occ;
    bit eof = 0;
    bit acc, xf;
    sent_q = {}; got_q = {}; xfer_cyc = {}; eof_cyc = -1;
    for (int c = 0; c < 3000; c++) begin
      msg_valid = (idx < msg_q.size()) && (mode != 2 || $urandom_range(0, 3) != 0);
      msg_data  = msg_valid ? msg_q[idx] : 8'h00;
      msg_last  = msg_valid && (idx == msg_q.size() - 1);
      msg_empty = 1'b0;
      F_rtr     = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) :
                  mode == 2 ? ($urandom_range(0, 1) == 1) : (c >= hold);
      H_ready   = (mode == 3) && (c == 10);
      #1;
      occ = sent_q.size() - got_q.size();
      acc = msg_valid && msg_ready;
      xf  = F_dr && F_rtr;
      if (occ == 8 && !xf) chk("ready_low_when_full", msg_ready, 0);
      if (xf) begin got_q.push_back(M); xfer_cyc.push_back(c); end
      if (acc) begin sent_q.push_back(msg_data); idx++; end
      chk("occupancy_le_depth", (sent_q.size() - got_q.size()) <= 8, 1);
      chk("no_early_done", done, 0);
      if (mode == 3 && c == 11) begin
        chk("spurious_h_done", done, 0);
        chk("spurious_h_busy", busy, 1);
        chk("spurious_h_fdr", F_dr, 1);
      end
      if (mode == 3 && c == hold - 1) begin
        chk("bp_accepted", sent_q.size(), 8);
        chk("bp_ready", msg_ready, 0);
        chk("bp_M", M, 8'h00);
      end
      if (End_Of_File) begin
        eof = 1; eof_cyc = c;
        chk("eof_after_all", got_q.size(), msg_q.size());
        chk("eof_no_fdr", F_dr, 0);
      end
      @(negedge clk);
      if (eof || (abort_at != 0 && got_q.size() == abort_at)) break;
    end
    msg_valid = 1'b0; msg_last = 1'b0; H_ready = 1'b0;
    if (abort_at == 0) begin
      chk("eof_reached", eof, 1);
      chk("got_count", got_q.size(), msg_q.size());
      for (int i = 0; i < msg_q.size() && i < got_q.size(); i++)
        chk($sformatf("byte_%0d", i), got_q[i], msg_q[i]);
    end
  endtask

  // called at a negedge while in FLUSH: stray beat, H_ready pulse, done, back to idle
  task automatic finish_msg();
    msg_valid = 1'b1; msg_data = 8'h55; msg_last = 1'b1; msg_empty = 1'b0; H_ready = 1'b0;
    #1;
    chk("flush_eof", End_Of_File, 1);
    chk("flush_ready", msg_ready, 0);
    chk("flush_fdr", F_dr, 0);
    @(negedge clk);
    msg_valid = 1'b0; msg_last = 1'b0; H_ready = 1'b1;
    #1;
    chk("flush_hold_eof", End_Of_File, 1);
    chk("flush_done", done, 0);
    @(negedge clk);
    H_ready = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("done_eof", End_Of_File, 0);
    chk("done_start", start, 1);
    @(negedge clk);
    #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_start", start, 0);
    chk("idle_ready", msg_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", msg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_fdr", F_dr, 0);
    chk("rst_eof", End_Of_File, 0);
    chk("rst_done", done, 0);
    chk("rst_M", M, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", msg_ready, 1);
    @(negedge clk);

    msg_q = '{8'hA5, 8'h3C, 8'h7E};
    run_msg(0, 0, 0);
    chk("consecutive_xfers", xfer_cyc[2] - xfer_cyc[0], 2);
    chk("eof_after_last", eof_cyc, xfer_cyc[2] + 1);
    finish_msg();

    msg_valid = 1'b1; msg_empty = 1'b1; msg_last = 1'b1;
    #1;
    chk("zl_ready", msg_ready, 1);
    @(negedge clk);
    msg_valid = 1'b0; msg_empty = 1'b0; msg_last = 1'b0;
    #1;
    chk("zl_eof", End_Of_File, 1);
    chk("zl_fdr", F_dr, 0);
    chk("zl_start", start, 1);
    @(negedge clk);
    finish_msg();

    msg_valid = 1'b1; msg_empty = 1'b1; msg_last = 1'b0; msg_data = 8'h11;
    @(negedge clk);
    msg_valid = 1'b0; msg_empty = 1'b0;
    #1;
    chk("proto_err_busy", busy, 0);
    chk("proto_err_fdr", F_dr, 0);
    @(negedge clk);

    msg_q = {};
    for (int i = 0; i < 12; i++) msg_q.push_back(8'(i));
    run_msg(3, 20, 0);
    finish_msg();

    msg_q = {};
    for (int i = 0; i < 20; i++) msg_q.push_back(8'(i * 7 + 3));
    run_msg(1, 0, 0);
    finish_msg();

    msg_q = {};
    for (int i = 0; i < 5; i++) msg_q.push_back(8'($urandom));
    run_msg(0, 0, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", msg_ready, 0);
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_start", start, 0);
    chk("midrst_fdr", F_dr, 0);
    chk("midrst_eof", End_Of_File, 0);
    chk("midrst_done", done, 0);
    chk("midrst_M", M, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", msg_ready, 1);
    chk("midrst_fifo_flushed", F_dr, 0);
    @(negedge clk);
    msg_q = '{8'hFF};
    run_msg(0, 0, 0);
    finish_msg();

    repeat (6) begin
      int len;
      len = $urandom_range(1, 20);
      msg_q = {};
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      run_msg(2, 0, 0);
      finish_msg();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
